// File: rtl/sd_defines.sv
// Shared SD controller build constants for the buffer-descriptor rings.
package sd_defines;

    localparam bit RAM_MEM_WIDTH_16 = 1'b1;
    localparam int RAM_MEM_WIDTH    = RAM_MEM_WIDTH_16 ? 16 : 32;
    localparam int BD_SIZE          = 8;

    function automatic int halves_of(input int width);
        return 64 / width;
    endfunction

    localparam int HALVES = halves_of(RAM_MEM_WIDTH);
    localparam int PTR_W  = $clog2(BD_SIZE);

endpackage

// File: rtl/sd_bd_ram.sv
// Simple dual-port descriptor RAM: one write port, one registered read port.
module sd_bd_ram #(
    parameter int W  = 16,
    parameter int AW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [2**AW];
    logic [W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Output register holds its value between reads; reset clears it only.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_rdata <= '0;
        else if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sd_bd_ring.sv
// Buffer-descriptor ring: packs half-word writes into descriptors, pops halves.
module sd_bd_ring #(
    parameter int RAM_MEM_WIDTH = sd_defines::RAM_MEM_WIDTH,
    parameter int BD_SIZE       = sd_defines::BD_SIZE
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     flush_i,
    input  logic                     we_m,
    input  logic [RAM_MEM_WIDTH-1:0] dat_in_m,
    input  logic                     re_s,
    output logic [RAM_MEM_WIDTH-1:0] dat_out_s,
    output logic                     ack_o_s,
    output logic [7:0]               free_bd,
    output logic                     empty_o,
    output logic                     wr_err_o
);

    import sd_defines::halves_of;

    localparam int HALVES = halves_of(RAM_MEM_WIDTH);
    localparam int HW     = $clog2(HALVES);
    localparam int PTR_W  = $clog2(BD_SIZE);
    localparam int AW     = PTR_W + HW;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [HW-1:0]    r_wr_half;
    logic [HW-1:0]    r_rd_half;
    logic [PTR_W:0]   r_count;
    logic [7:0]       r_free;
    logic             r_empty;
    logic             r_ack;
    logic             r_err;

    logic             w_clr;
    logic             w_full;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_commit;
    logic             w_release;
    logic [PTR_W:0]   w_count_nxt;
    logic [RAM_MEM_WIDTH-1:0] w_rdata;

    assign w_clr     = wb_rst_i | flush_i;
    assign w_full    = (r_count == (PTR_W+1)'(BD_SIZE));
    assign w_wr_ok   = we_m & ~w_full & ~w_clr;
    assign w_rd_ok   = re_s & (r_count != '0) & ~w_clr;
    assign w_commit  = w_wr_ok & (r_wr_half == HW'(HALVES-1));
    assign w_release = w_rd_ok & (r_rd_half == HW'(HALVES-1));

    always_comb begin
        w_count_nxt = r_count;
        if (w_commit & ~w_release)
            w_count_nxt = r_count + (PTR_W+1)'(1);
        else if (w_release & ~w_commit)
            w_count_nxt = r_count - (PTR_W+1)'(1);
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_clr) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_wr_half <= '0;
            r_rd_half <= '0;
            r_count   <= '0;
            r_free    <= 8'(BD_SIZE);
            r_empty   <= 1'b1;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_half <= w_commit ? '0 : r_wr_half + HW'(1);
                if (w_commit)
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_ok) begin
                r_rd_half <= w_release ? '0 : r_rd_half + HW'(1);
                if (w_release)
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            // Status tracks the updated count so it never lags a commit.
            r_count <= w_count_nxt;
            r_free  <= 8'(BD_SIZE) - 8'(w_count_nxt);
            r_empty <= (w_count_nxt == '0);
            r_ack   <= w_rd_ok;
            r_err   <= we_m & w_full;
        end
    end

    sd_bd_ram #(
        .W  (RAM_MEM_WIDTH),
        .AW (AW)
    ) u_ram (
        .i_clk   (wb_clk_i),
        .i_rst   (w_clr),
        .i_we    (w_wr_ok),
        .i_waddr ({r_wr_ptr, r_wr_half}),
        .i_wdata (dat_in_m),
        .i_re    (w_rd_ok),
        .i_raddr ({r_rd_ptr, r_rd_half}),
        .o_rdata (w_rdata)
    );

    assign dat_out_s = w_rdata;
    assign ack_o_s   = r_ack;
    assign free_bd   = r_free;
    assign empty_o   = r_empty;
    assign wr_err_o  = r_err;

endmodule

// File: tb/tb_sd_bd_ring.sv
// Directed checks for sd_bd_ring at RAM_MEM_WIDTH=16, BD_SIZE=8.
module tb_sd_bd_ring;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        we = 1'b0;
    logic [15:0] din = '0;
    logic        re = 1'b0;
    logic [15:0] dout;
    logic        ack;
    logic [7:0]  free_bd;
    logic        empty;
    logic        err;

    int checks = 0;
    int failures = 0;

    sd_bd_ring #(.RAM_MEM_WIDTH(16), .BD_SIZE(8)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .flush_i   (flush),
        .we_m      (we),
        .dat_in_m  (din),
        .re_s      (re),
        .dat_out_s (dout),
        .ack_o_s   (ack),
        .free_bd   (free_bd),
        .empty_o   (empty),
        .wr_err_o  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] d;
        logic        re;
        logic [7:0]  free;
        logic        empty;
        logic        ack;
        logic        cd;
        logic [15:0] dout;
        logic        err;
    } vec_t;

    vec_t v[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic [15:0] d, input logic r,
                        input logic f, input logic rs);
        we = w; din = d; re = r; flush = f; rst = rs;
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic wr(input logic [15:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input string name, input logic [15:0] exp);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk({name, "_ack"}, 32'(ack), 32'd1);
        chk({name, "_dat"}, 32'(dout), 32'(exp));
    endtask

    task automatic status(input string name, input logic [7:0] f,
                          input logic e);
        chk({name, "_free"}, 32'(free_bd), 32'(f));
        chk({name, "_empty"}, 32'(empty), 32'(e));
    endtask

    task automatic clear_mid(input logic use_rst, input string name);
        for (int i = 0; i < 4; i++) wr(16'h5000 + 16'(i));
        wr(16'h5004);
        wr(16'h5005);
        rd({name, "_pre"}, 16'h5000);
        step(1'b0, 16'h0, 1'b0, ~use_rst, use_rst);
        status(name, 8'd8, 1'b1);
        chk({name, "_ack"}, 32'(ack), 32'd0);
        chk({name, "_dout"}, 32'(dout), 32'd0);
        wr(16'h000A); wr(16'h000B); wr(16'h000C); wr(16'h000D);
        status({name, "_new"}, 8'd7, 1'b0);
        rd({name, "_a"}, 16'h000A);
        rd({name, "_b"}, 16'h000B);
        rd({name, "_c"}, 16'h000C);
        rd({name, "_d"}, 16'h000D);
        status({name, "_end"}, 8'd8, 1'b1);
    endtask

    initial begin
        v[0] = '{1'b0, 16'h0000, 1'b0, 8'd8, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        v[1] = '{1'b1, 16'h1000, 1'b0, 8'd8, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        v[2] = '{1'b1, 16'h0000, 1'b0, 8'd8, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        v[3] = '{1'b1, 16'h0020, 1'b0, 8'd8, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        v[4] = '{1'b1, 16'h0000, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        v[5] = '{1'b0, 16'h0000, 1'b1, 8'd7, 1'b0, 1'b1, 1'b1, 16'h1000, 1'b0};
        v[6] = '{1'b0, 16'h0000, 1'b1, 8'd7, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0};
        v[7] = '{1'b0, 16'h0000, 1'b1, 8'd7, 1'b0, 1'b1, 1'b1, 16'h0020, 1'b0};
        v[8] = '{1'b0, 16'h0000, 1'b1, 8'd8, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0};
        v[9] = '{1'b0, 16'h0000, 1'b0, 8'd8, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};

        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);

        for (int i = 0; i < 10; i++) begin
            step(v[i].we, v[i].d, v[i].re, 1'b0, 1'b0);
            chk($sformatf("vec%0d_free", i), 32'(free_bd), 32'(v[i].free));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(v[i].empty));
            chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(v[i].ack));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(v[i].err));
            if (v[i].cd)
                chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(v[i].dout));
        end

        for (int i = 0; i < 32; i++) wr(16'h0100 + 16'(i));
        status("full", 8'd0, 1'b0);
        wr(16'hDEAD);
        chk("full_err", 32'(err), 32'd1);
        status("full_drop", 8'd0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("full_err_pulse", 32'(err), 32'd0);
        for (int i = 0; i < 32; i++)
            rd($sformatf("drain%0d", i), 16'h0100 + 16'(i));
        status("drained", 8'd8, 1'b1);

        for (int i = 0; i < 32; i++) wr(16'h2000 + 16'(i));
        for (int i = 0; i < 12; i++)
            rd($sformatf("wrap_a%0d", i), 16'h2000 + 16'(i));
        status("wrap_part", 8'd3, 1'b0);
        for (int i = 0; i < 12; i++) wr(16'h3000 + 16'(i));
        status("wrap_full", 8'd0, 1'b0);
        for (int i = 12; i < 32; i++)
            rd($sformatf("wrap_b%0d", i), 16'h2000 + 16'(i));
        for (int i = 0; i < 12; i++)
            rd($sformatf("wrap_c%0d", i), 16'h3000 + 16'(i));
        status("wrap_end", 8'd8, 1'b1);

        for (int k = 0; k < 19; k++) wr(16'h4000 + 16'(k));
        for (int k = 0; k < 3; k++)
            rd($sformatf("sim_pre%0d", k), 16'h4000 + 16'(k));
        status("sim_before", 8'd4, 1'b0);
        step(1'b1, 16'h4013, 1'b1, 1'b0, 1'b0);
        chk("sim_ack", 32'(ack), 32'd1);
        chk("sim_dat", 32'(dout), 32'h4003);
        status("sim_after", 8'd4, 1'b0);
        for (int k = 4; k < 20; k++)
            rd($sformatf("sim_post%0d", k), 16'h4000 + 16'(k));
        status("sim_end", 8'd8, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("rd_empty_ack", 32'(ack), 32'd0);
        chk("rd_empty_dout", 32'(dout), 32'h4013);
        status("rd_empty", 8'd8, 1'b1);

        clear_mid(1'b0, "flush");
        clear_mid(1'b1, "reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
